// File: rtl/scarv_mem_pkg.sv
// Shared memory-bus constants for the SCARV SoC: bus widths and the
// requester index assignment used by the memory arbiter.
package scarv_mem_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_STRB_W = 4;

    localparam logic RQ_IFETCH = 1'b0;
    localparam logic RQ_DATA   = 1'b1;

endpackage

// File: rtl/scarv_mem_arb_owner_fifo.sv
// Records which requester issued each in-flight transaction so that
// responses can be routed back in issue order.
module scarv_mem_arb_owner_fifo #(
    parameter int DEPTH = 2,
    parameter int CW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          push_data,
    input  logic          pop,
    output logic          head,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [DEPTH-1:0] mem_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW-1:0]    wr_ptr_r;
    logic [CW-1:0]    count_r;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? PW'(0) : p + PW'(1);
    endfunction

    // Storage, pointers and occupancy; push and pop together keep count steady.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_r    <= '0;
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= next_ptr(wr_ptr_r);
            end
            if (pop) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/scarv_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch
// (requester 0) and data (requester 1), with in-order response routing.
module scarv_mem_arbiter
    import scarv_mem_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int OW              = 2
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic [1:0]  rq_req,
    output logic [1:0]  rq_gnt,
    input  logic [1:0]  rq_wen,
    input  logic [7:0]  rq_strb,
    input  logic [63:0] rq_addr,
    input  logic [63:0] rq_wdata,
    output logic [1:0]  rq_recv,
    input  logic [1:0]  rq_ack,
    output logic        rq_error,
    output logic [31:0] rq_rdata,
    output logic        s_req,
    input  logic        s_gnt,
    output logic        s_wen,
    output logic [3:0]  s_strb,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_recv,
    output logic        s_ack,
    input  logic        s_error,
    input  logic [31:0] s_rdata,
    output logic [OW-1:0] outstanding
);

    logic          last_gnt_r;
    logic          lock_r;
    logic          lock_sel_r;
    logic          sel_s;
    logic          can_issue_s;
    logic          push_s;
    logic          pop_s;
    logic          head_s;
    logic          nonempty_s;
    logic [OW-1:0] count_s;

    // Requester selection; a stalled request stays locked to its owner.
    always_comb begin
        sel_s = RQ_IFETCH;
        if (lock_r) begin
            sel_s = lock_sel_r;
        end else if (rq_req == 2'b11) begin
            sel_s = ~last_gnt_r;
        end else if (rq_req[1]) begin
            sel_s = RQ_DATA;
        end else begin
            sel_s = RQ_IFETCH;
        end
    end

    assign nonempty_s  = (count_s != OW'(0));
    assign can_issue_s = (count_s < OW'(MAX_OUTSTANDING)) | pop_s;
    assign s_req       = rq_req[sel_s] & can_issue_s & ~g_reset;
    assign s_wen       = rq_wen[sel_s];
    assign s_strb      = rq_strb[{sel_s, 2'b00} +: MEM_STRB_W];
    assign s_addr      = rq_addr[{sel_s, 5'b00000} +: MEM_ADDR_W];
    assign s_wdata     = rq_wdata[{sel_s, 5'b00000} +: MEM_DATA_W];
    assign push_s      = s_req & s_gnt;
    assign pop_s       = s_recv & s_ack & nonempty_s;

    // Request grant back to the selected requester only.
    always_comb begin
        rq_gnt        = 2'b00;
        rq_gnt[sel_s] = push_s;
    end

    // Response routing to the oldest owner; orphan responses are drained.
    always_comb begin
        rq_recv = 2'b00;
        s_ack   = 1'b1;
        if (nonempty_s) begin
            rq_recv[head_s] = s_recv & ~g_reset;
            s_ack           = rq_ack[head_s];
        end else begin
            rq_recv = 2'b00;
            s_ack   = 1'b1;
        end
    end

    assign rq_rdata    = s_rdata;
    assign rq_error    = s_error;
    assign outstanding = g_reset ? OW'(0) : count_s;

    // Round-robin history and request lock.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            last_gnt_r <= 1'b1;
            lock_r     <= 1'b0;
            lock_sel_r <= 1'b0;
        end else if (push_s) begin
            last_gnt_r <= sel_s;
            lock_r     <= 1'b0;
        end else if (s_req) begin
            lock_r     <= 1'b1;
            lock_sel_r <= sel_s;
        end else begin
            lock_r     <= lock_r;
        end
    end

    scarv_mem_arb_owner_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .CW    (OW)
    ) u_owner_fifo (
        .clk       (g_clk),
        .reset     (g_reset),
        .push      (push_s),
        .push_data (sel_s),
        .pop       (pop_s),
        .head      (head_s),
        .count     (count_s)
    );

endmodule

// File: tb/tb_scarv_mem_arbiter.sv
// Directed scenarios plus randomized traffic checked against a queue-based
// model of the arbiter's grant and response-routing rules.
module tb_scarv_mem_arbiter;

    localparam int MAXO = 2;

    logic        g_clk = 1'b0;
    logic        g_reset;
    logic [1:0]  rq_req, rq_gnt, rq_wen, rq_recv, rq_ack;
    logic [7:0]  rq_strb;
    logic [63:0] rq_addr, rq_wdata;
    logic        rq_error, s_req, s_gnt, s_wen, s_recv, s_ack, s_error;
    logic [3:0]  s_strb;
    logic [31:0] rq_rdata, s_addr, s_wdata, s_rdata;
    logic [1:0]  outstanding;

    int checks   = 0;
    int failures = 0;

    int q[$];
    bit m_last, m_lock, m_lock_who;
    bit e_push, e_pop, e_who;
    bit rnd_drive = 1'b0;

    always #5 g_clk = ~g_clk;

    scarv_mem_arbiter #(.MAX_OUTSTANDING(MAXO), .OW(2)) dut (
        .g_clk(g_clk), .g_reset(g_reset),
        .rq_req(rq_req), .rq_gnt(rq_gnt), .rq_wen(rq_wen), .rq_strb(rq_strb),
        .rq_addr(rq_addr), .rq_wdata(rq_wdata), .rq_recv(rq_recv), .rq_ack(rq_ack),
        .rq_error(rq_error), .rq_rdata(rq_rdata),
        .s_req(s_req), .s_gnt(s_gnt), .s_wen(s_wen), .s_strb(s_strb),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_recv(s_recv), .s_ack(s_ack),
        .s_error(s_error), .s_rdata(s_rdata), .outstanding(outstanding)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Settle inputs, predict from the model, compare every visible output.
    task automatic eval();
        bit room;
        bit [1:0] exp_recv;
        #1;
        e_push = 1'b0;
        e_pop  = 1'b0;
        if (g_reset) begin
            check_eq("rst_s_req", s_req, 1'b0);
            check_eq("rst_gnt", rq_gnt, 2'b00);
            check_eq("rst_recv", rq_recv, 2'b00);
            check_eq("rst_outstanding", outstanding, 2'd0);
        end else begin
            e_pop = (q.size() > 0) && s_recv && rq_ack[q[0]];
            room  = (q.size() < MAXO) || e_pop;
            if (m_lock)               e_who = m_lock_who;
            else if (rq_req == 2'b11) e_who = ~m_last;
            else                      e_who = rq_req[1];
            e_push = rq_req[e_who] && room && s_gnt;
            check_eq("s_req", s_req, rq_req[e_who] && room);
            check_eq("rq_gnt", rq_gnt, e_push ? (2'b01 << e_who) : 2'b00);
            if (rq_req[e_who] && room) begin
                check_eq("s_addr", s_addr, rq_addr[e_who*32 +: 32]);
                check_eq("s_wdata", s_wdata, rq_wdata[e_who*32 +: 32]);
                check_eq("s_strb", s_strb, rq_strb[e_who*4 +: 4]);
                check_eq("s_wen", s_wen, rq_wen[e_who]);
            end
            exp_recv = (q.size() > 0) ? (2'(s_recv) << q[0]) : 2'b00;
            check_eq("rq_recv", rq_recv, exp_recv);
            check_eq("s_ack", s_ack, (q.size() > 0) ? rq_ack[q[0]] : 1'b1);
            check_eq("outstanding", outstanding, q.size());
            if (s_recv) begin
                check_eq("rq_rdata", rq_rdata, s_rdata);
                check_eq("rq_error", rq_error, s_error);
            end
        end
    endtask

    // Clock edge: advance the model, then drive new inputs on the falling edge.
    task automatic advance();
        @(posedge g_clk);
        if (g_reset) begin
            q.delete();
            m_last = 1'b1;
            m_lock = 1'b0;
        end else begin
            if (e_pop) void'(q.pop_front());
            if (e_push) begin
                q.push_back(int'(e_who));
                m_last = e_who;
                m_lock = 1'b0;
            end else if (rq_req[e_who] && s_req) begin
                m_lock     = 1'b1;
                m_lock_who = e_who;
            end
        end
        @(negedge g_clk);
        if (rnd_drive) begin
            for (int i = 0; i < 2; i++) begin
                if ((e_push && e_who == i[0]) || !rq_req[i]) begin
                    rq_req[i]             = 1'($urandom_range(0, 1));
                    rq_wen[i]             = 1'($urandom_range(0, 1));
                    rq_strb[i*4 +: 4]     = 4'($urandom);
                    rq_addr[i*32 +: 32]   = $urandom;
                    rq_wdata[i*32 +: 32]  = $urandom;
                end
            end
            s_gnt   = 1'($urandom_range(0, 1));
            s_recv  = 1'($urandom_range(0, 1));
            rq_ack  = 2'($urandom);
            s_rdata = $urandom;
            s_error = 1'($urandom_range(0, 1));
            g_reset = ($urandom_range(0, 99) == 0);
        end
    endtask

    task automatic do_reset();
        rq_req = 2'b00; rq_wen = 2'b00; rq_strb = 8'h00; rq_addr = 64'd0;
        rq_wdata = 64'd0; rq_ack = 2'b00; s_gnt = 1'b0; s_recv = 1'b0;
        s_error = 1'b0; s_rdata = 32'd0; g_reset = 1'b1;
        eval();
        advance();
        g_reset = 1'b0;
    endtask

    initial begin
        @(negedge g_clk);
        do_reset();

        // Single fetch request and its response.
        rq_req = 2'b01; rq_addr[31:0] = 32'h0000_0100; s_gnt = 1'b1;
        eval();
        check_eq("t1_s_req", s_req, 1'b1);
        check_eq("t1_s_addr", s_addr, 32'h100);
        check_eq("t1_gnt", rq_gnt, 2'b01);
        advance();
        rq_req = 2'b00; s_recv = 1'b1; s_rdata = 32'hDEAD_BEEF; rq_ack = 2'b01;
        eval();
        check_eq("t1_outstanding", outstanding, 2'd1);
        check_eq("t1_recv", rq_recv, 2'b01);
        check_eq("t1_rdata", rq_rdata, 32'hDEAD_BEEF);
        advance();
        s_recv = 1'b0;
        eval();
        check_eq("t1_drained", outstanding, 2'd0);
        advance();

        // Alternating grants under continuous contention.
        do_reset();
        rq_req = 2'b11; s_gnt = 1'b1; s_recv = 1'b1; rq_ack = 2'b11;
        for (int i = 0; i < 4; i++) begin
            eval();
            check_eq("t2_alt", rq_gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
            advance();
        end

        // Stalled request stays locked to requester 0.
        do_reset();
        rq_req = 2'b01; rq_addr = {32'h0000_0300, 32'h0000_0200};
        for (int i = 0; i < 3; i++) begin
            if (i == 1) rq_req = 2'b11;
            eval();
            check_eq("t3_lock_addr", s_addr, 32'h200);
            advance();
        end
        s_gnt = 1'b1;
        eval();
        check_eq("t3_gnt0", rq_gnt, 2'b01);
        advance();
        eval();
        check_eq("t3_gnt1", rq_gnt, 2'b10);
        advance();

        // Full pipeline, then pop and push in the same cycle.
        do_reset();
        rq_req = 2'b01; s_gnt = 1'b1;
        eval(); advance(); eval(); advance();
        eval();
        check_eq("t4_full_sreq", s_req, 1'b0);
        check_eq("t4_full_cnt", outstanding, 2'd2);
        s_recv = 1'b1; rq_ack = 2'b01;
        eval();
        check_eq("t4_swap_gnt", rq_gnt, 2'b01);
        advance();
        s_recv = 1'b0;
        eval();
        check_eq("t4_swap_cnt", outstanding, 2'd2);
        advance();

        // In-order routing with a back-pressured response.
        do_reset();
        s_gnt = 1'b1; rq_req = 2'b10; eval(); advance();
        rq_req = 2'b01; eval(); advance();
        rq_req = 2'b00; s_recv = 1'b1; s_rdata = 32'h11; rq_ack = 2'b00;
        for (int i = 0; i < 2; i++) begin
            eval();
            check_eq("t5_hold_ack", s_ack, 1'b0);
            check_eq("t5_hold_recv", rq_recv, 2'b10);
            advance();
        end
        rq_ack = 2'b10; eval();
        check_eq("t5_first_ack", s_ack, 1'b1);
        advance();
        s_rdata = 32'h22; rq_ack = 2'b01; eval();
        check_eq("t5_second_recv", rq_recv, 2'b01);
        check_eq("t5_second_data", rq_rdata, 32'h22);
        advance();

        // Spurious response, then reset with two in flight.
        do_reset();
        s_recv = 1'b1; rq_ack = 2'b00;
        eval();
        check_eq("t6_spur_ack", s_ack, 1'b1);
        check_eq("t6_spur_recv", rq_recv, 2'b00);
        advance();
        s_recv = 1'b0; s_gnt = 1'b1; rq_req = 2'b10;
        eval(); advance(); eval(); advance();
        s_gnt = 1'b0; rq_req = 2'b11; g_reset = 1'b1;
        eval(); advance();
        g_reset = 1'b0; s_gnt = 1'b1;
        eval();
        check_eq("t6_rst_cnt", outstanding, 2'd0);
        check_eq("t6_rst_gnt", rq_gnt, 2'b01);
        advance();

        // Randomized traffic against the model.
        rnd_drive = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            eval();
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
